// File: rtl/onehot_select_pkg.sv
// Shared types and constants for the one-hot select generator.
package onehot_select_pkg;

    // Controller states: idle (outputs off), holding a decoded index,
    // or autonomously sweeping through every output.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        SWEEP = 2'd2
    } sel_state_t;

    // Values of the mode input, sampled when a request is accepted.
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SWEEP  = 1'b1;

endpackage : onehot_select_pkg

// File: rtl/onehot_dec.sv
// Combinational index to one-hot decoder, OUT_W = 2**ADDR_W outputs.
module onehot_dec #(
    parameter int ADDR_W = 3
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic [(2**ADDR_W)-1:0] onehot
);

    // Exactly one output bit is set, selected by addr.
    always_comb begin
        onehot       = '0;
        onehot[addr] = 1'b1;
    end

endmodule : onehot_dec

// File: rtl/onehot_select_seq.sv
// Registered one-hot select generator with a direct-decode hold mode and
// an autonomous sweep mode that has a programmable dwell per output.
module onehot_select_seq
    import onehot_select_pkg::*;
#(
    parameter int ADDR_W  = 3,
    parameter int DWELL_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DWELL_W-1:0]     dwell,
    output logic [(2**ADDR_W)-1:0] d,
    output logic                   d_valid,
    output logic                   wrap
);

    localparam int OUT_W = 2**ADDR_W;

    sel_state_t         state;
    sel_state_t         state_nxt;
    logic [ADDR_W-1:0]  idx;
    logic [ADDR_W-1:0]  idx_nxt;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_nxt;
    logic [DWELL_W-1:0] dwell_lat;
    logic [DWELL_W-1:0] dwell_lat_nxt;
    logic [OUT_W-1:0]   d_nxt;
    logic               d_valid_nxt;
    logic               wrap_nxt;
    logic [OUT_W-1:0]   dec_onehot;
    logic               accept;

    // Requests are taken whenever enabled and not sweeping; the reset term
    // keeps in_ready low while rst_n is asserted.
    assign in_ready = rst_n && en && (state != SWEEP);
    assign accept   = in_valid && in_ready;

    // The decoder sits on the next-index path so the select lands in the
    // output register on the same edge as the index.
    onehot_dec #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .addr   (idx_nxt),
        .onehot (dec_onehot)
    );

    // Next-state, index, dwell counter and output computation.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        cnt_nxt       = cnt;
        dwell_lat_nxt = dwell_lat;
        wrap_nxt      = 1'b0;

        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        idx_nxt = addr;
                        if (mode == MODE_SWEEP) begin
                            state_nxt     = SWEEP;
                            cnt_nxt       = dwell;
                            dwell_lat_nxt = dwell;
                        end else begin
                            state_nxt = HOLD;
                        end
                    end
                end
                SWEEP: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - DWELL_W'(1);
                    end else begin
                        idx_nxt  = idx + ADDR_W'(1);
                        cnt_nxt  = dwell_lat;
                        wrap_nxt = &idx;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        d_valid_nxt = (state_nxt != IDLE);
        d_nxt       = d_valid_nxt ? dec_onehot : '0;
    end

    // State, sweep bookkeeping and registered outputs; reset clears all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            dwell_lat <= '0;
            d         <= '0;
            d_valid   <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            dwell_lat <= dwell_lat_nxt;
            d         <= d_nxt;
            d_valid   <= d_valid_nxt;
            wrap      <= wrap_nxt;
        end
    end

endmodule : onehot_select_seq

// File: tb/tb_onehot_select_seq.sv
// Directed self-checking bench for onehot_select_seq (ADDR_W=3, DWELL_W=8).
module tb_onehot_select_seq;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] addr;
    logic [7:0] dwell;
    logic [7:0] d;
    logic       d_valid;
    logic       wrap;

    int nAssert = 0;
    int nFail   = 0;

    onehot_select_seq #(
        .ADDR_W  (3),
        .DWELL_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .addr     (addr),
        .dwell    (dwell),
        .d        (d),
        .d_valid  (d_valid),
        .wrap     (wrap)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output invariant sampled every falling edge: one-hot when valid,
    // all-zero otherwise, and wrap only with a valid select.
    always @(negedge clk) begin
        nAssert++;
        assert (d_valid ? $onehot(d) : (d === 8'h00)) else begin
            nFail++;
            $error("[TB] FAIL invariant: observed d=%h d_valid=%b expected one-hot or zero", d, d_valid);
        end
        nAssert++;
        assert (!(wrap === 1'b1 && d_valid !== 1'b1)) else begin
            nFail++;
            $error("[TB] FAIL wrap_valid: observed wrap=%b d_valid=%b expected wrap only when valid", wrap, d_valid);
        end
    end

    // Drive all request inputs, then let combinational in_ready settle.
    task automatic applyStimulus(input logic e, input logic v, input logic m,
                                 input logic [2:0] a, input logic [7:0] dw);
        en       = e;
        in_valid = v;
        mode     = m;
        addr     = a;
        dwell    = dw;
        #1;
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare the registered outputs against expected values.
    task automatic checkOutput(input string tag, input logic [7:0] expD,
                               input logic expV, input logic expW);
        nAssert++;
        assert (d === expD) else begin
            nFail++;
            $error("[TB] FAIL %s d: observed %h expected %h", tag, d, expD);
        end
        nAssert++;
        assert (d_valid === expV) else begin
            nFail++;
            $error("[TB] FAIL %s d_valid: observed %b expected %b", tag, d_valid, expV);
        end
        nAssert++;
        assert (wrap === expW) else begin
            nFail++;
            $error("[TB] FAIL %s wrap: observed %b expected %b", tag, wrap, expW);
        end
    endtask

    // Compare the combinational ready output.
    task automatic checkReady(input string tag, input logic expR);
        nAssert++;
        assert (in_ready === expR) else begin
            nFail++;
            $error("[TB] FAIL %s in_ready: observed %b expected %b", tag, in_ready, expR);
        end
    endtask

    // Expected outputs for the addr=6, dwell=2 sweep after its first cycle.
    logic [7:0] sweepD [8] = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h80, 8'h01, 8'h01, 8'h01};
    logic       sweepW [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Directed sequence.
    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        #1;
        checkOutput("reset", 8'h00, 1'b0, 1'b0);
        checkReady("reset", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("idle", 8'h00, 1'b0, 1'b0);
        checkReady("idle", 1'b1);

        $display("[TB] direct accept addr=5");
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd5, 8'd0);
        tick();
        checkOutput("direct5", 8'h20, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd2, 8'd0);
        tick();
        checkOutput("hold5_a", 8'h20, 1'b1, 1'b0);
        tick();
        checkOutput("hold5_b", 8'h20, 1'b1, 1'b0);

        $display("[TB] direct stream 0,1,7");
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 8'd0);
        checkReady("stream0", 1'b1);
        tick();
        checkOutput("stream0", 8'h01, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd1, 8'd0);
        checkReady("stream1", 1'b1);
        tick();
        checkOutput("stream1", 8'h02, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd7, 8'd0);
        checkReady("stream7", 1'b1);
        tick();
        checkOutput("stream7", 8'h80, 1'b1, 1'b0);

        $display("[TB] sweep addr=6 dwell=2");
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd6, 8'd2);
        tick();
        checkOutput("sweep6_0", 8'h40, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 8'd0);
        for (int i = 0; i < 8; i++) begin
            checkReady("sweep6_rdy", 1'b0);
            tick();
            checkOutput($sformatf("sweep6_%0d", i + 1), sweepD[i], 1'b1, sweepW[i]);
        end

        $display("[TB] en drop mid-sweep with in_valid high");
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd2, 8'd0);
        checkReady("endrop", 1'b0);
        tick();
        checkOutput("endrop", 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd2, 8'd0);
        checkReady("reenable", 1'b1);
        tick();
        checkOutput("reenable", 8'h04, 1'b1, 1'b0);

        $display("[TB] sweep addr=0 dwell=0");
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 8'd0);
        tick();
        checkOutput("sweep0_0", 8'h01, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            checkOutput($sformatf("sweep0_%0d", i), 8'h01 << (i % 8), 1'b1, (i == 8));
        end

        $display("[TB] reset mid-sweep");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_sweep", 8'h00, 1'b0, 1'b0);
        checkReady("rst_sweep", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        tick();
        checkOutput("after_rst", 8'h00, 1'b0, 1'b0);

        $display("[TB] reset mid-hold");
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 8'd0);
        tick();
        checkOutput("hold3", 8'h08, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_hold", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_end", 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule : tb_onehot_select_seq
